// File: rtl/midi_uart_tx.sv
// Serial byte transmitter with a small input FIFO. Frames each queued byte as
// start, LSB-first data, stop bit(s) and an optional idle gap on a line that idles high.
module midi_uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 38400,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int GAP_BITS   = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_en,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          tx,
  output logic                          busy,
  output logic                          byte_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int LVL_W        = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [3:0]       GAP_LAST  = 4'(GAP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 byte_done_q, byte_done_d;
  logic                 overflow_q, overflow_d;
  logic                 full_q, full_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  logic push, pop, bit_tick, next_frame;

  // full is the registered flag, so a pop in the same cycle never frees a slot early.
  always_comb begin
    push       = wr_en && !full_q;
    overflow_d = wr_en && full_q;
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
    full_d     = (level_d == LVL_W'(FIFO_DEPTH));
  end

  // NOTE: the storage array has no reset; level/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  // NOTE: every _d gets a default first so no branch can leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    pop         = 1'b0;
    byte_done_d = 1'b0;
    next_frame  = 1'b0;
    bit_tick    = (cnt_q == CNT_LAST);

    if (state_q != S_IDLE) cnt_d = bit_tick ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_tick) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            state_d = S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          if (bit_q == STOP_LAST) begin
            byte_done_d = 1'b1;
            bit_d       = '0;
            if (GAP_BITS > 0) state_d = S_GAP;
            else              next_frame = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_GAP: begin
        if (bit_tick) begin
          if (bit_q == GAP_LAST) begin
            bit_d      = '0;
            next_frame = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Chaining straight into the next start bit keeps back-to-back frames gapless.
    if (next_frame) begin
      if (level_q != '0) begin
        pop     = 1'b1;
        shift_d = mem[rd_ptr_q];
        state_d = S_START;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      byte_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      full_q      <= 1'b0;
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      byte_done_q <= byte_done_d;
      overflow_q  <= overflow_d;
      full_q      <= full_d;
      level_q     <= level_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // tx and byte_done are registered together, so the pulse lines up with the last stop-bit clock on the line.
  assign tx        = tx_q;
  assign byte_done = byte_done_q;
  assign overflow  = overflow_q;
  assign full      = full_q;
  assign level     = level_q;
  assign busy      = (state_q != S_IDLE);

endmodule
